// File: rtl/pipe_pkg.sv
// Shared pipeline types: fetch-state encoding, bubble instruction and the IF/ID payload.
package pipe_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [31:0]     instr;
    logic            valid;
  } ifid_t;
endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory req/ack port: the fetch stage is master, memory is slave.
interface if_fetch_stage_if #(parameter int XLEN = pipe_pkg::XLEN);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} buffer catching an instruction that returns while IF/ID is stalled.
module if_skid_buf #(
  parameter int XLEN = pipe_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic            full,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);
  // Only the full flag needs a reset; the payload is qualified by it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end
  end
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the imem req/ack port, and holds the IF/ID register.
module if_fetch_stage #(
  parameter int              XLEN      = pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [XLEN-1:0]    branch_target,
  if_fetch_stage_if.master   imem,
  output logic [XLEN-1:0]    pc_out,
  output logic [XLEN-1:0]    npc_out,
  output logic [31:0]        instr_out,
  output logic               valid_out
);
  import pipe_pkg::*;

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q, redir_q, pc_inc;
  logic            redirect_pend;
  ifid_t           ifid_q;

  logic            ack_fetch, skid_load, skid_clear, skid_full;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;

  assign ack_fetch      = imem.imem_ack && (state_q == FETCH);
  assign pc_inc         = pc_q + XLEN'(4);
  assign imem.imem_req  = (state_q == FETCH) && !reset;
  assign imem.imem_addr = pc_q;

  assign skid_load  = !reset && !flush && ack_fetch && !redirect_pend && stall;
  assign skid_clear = reset || flush || ((state_q == HOLD) && !stall);

  if_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .clear    (skid_clear),
    .pc_in    (pc_q),
    .instr_in (imem.imem_rdata),
    .full     (skid_full),
    .pc       (skid_pc),
    .instr    (skid_instr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      redir_q       <= '0;
      redirect_pend <= 1'b0;
      state_q       <= FETCH;
      ifid_q        <= '{pc: '0, npc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (flush) begin
      ifid_q.instr <= NOP_INSTR;
      ifid_q.valid <= 1'b0;
      // An outstanding request cannot be withdrawn: remember the target and drop its data later.
      if ((state_q == FETCH) && !imem.imem_ack) begin
        redirect_pend <= 1'b1;
        redir_q       <= branch_target;
      end else begin
        redirect_pend <= 1'b0;
        pc_q          <= branch_target;
        state_q       <= FETCH;
      end
    end else if (state_q == FETCH) begin
      if (ack_fetch && redirect_pend) begin
        pc_q          <= redir_q;
        redirect_pend <= 1'b0;
        if (!stall) begin
          ifid_q.instr <= NOP_INSTR;
          ifid_q.valid <= 1'b0;
        end
      end else if (ack_fetch) begin
        pc_q <= pc_inc;
        if (!stall) ifid_q  <= '{pc: pc_q, npc: pc_inc, instr: imem.imem_rdata, valid: 1'b1};
        else        state_q <= HOLD;
      end else if (!stall) begin
        ifid_q.instr <= NOP_INSTR;
        ifid_q.valid <= 1'b0;
      end
    end else if (!stall && skid_full) begin
      ifid_q  <= '{pc: skid_pc, npc: skid_pc + XLEN'(4), instr: skid_instr, valid: 1'b1};
      state_q <= FETCH;
    end
  end

  assign pc_out    = ifid_q.pc;
  assign npc_out   = ifid_q.npc;
  assign instr_out = ifid_q.instr;
  assign valid_out = ifid_q.valid;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random stall/flush/latency against a reference model.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] branch_target, pc_out, npc_out, instr_out;
  logic        valid_out;

  if_fetch_stage_if mif();

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .branch_target(branch_target),
    .imem(mif.master), .pc_out(pc_out), .npc_out(npc_out), .instr_out(instr_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int wcnt = 0, lat = 0;

  // Reference model: next fetch address, whether a request is live, pending redirect, skid queue, IF/ID.
  logic [31:0] m_pc = 32'h0, m_tgt = 32'h0;
  bit          m_fetch = 1'b0, m_pend = 1'b0;
  logic [63:0] m_skid[$];
  logic [31:0] e_pc = 0, e_npc = 0, e_instr = NOP;
  logic        e_valid = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bubble();
    e_instr = NOP;
    e_valid = 1'b0;
  endtask

  task automatic model_update(input bit rst, input bit st, input bit fl, input logic [31:0] bt,
                              input bit ak, input logic [31:0] rd);
    logic [63:0] e;
    if (rst) begin
      m_pc = 32'h0; m_fetch = 1'b1; m_pend = 1'b0; m_skid.delete();
      e_pc = 0; e_npc = 0; e_instr = NOP; e_valid = 1'b0;
    end else if (fl) begin
      bubble();
      m_skid.delete();
      if (m_fetch && !ak) begin m_pend = 1'b1; m_tgt = bt; end
      else begin m_pc = bt; m_fetch = 1'b1; m_pend = 1'b0; end
    end else if (m_fetch) begin
      if (ak && m_pend) begin
        m_pc = m_tgt; m_pend = 1'b0;
        if (!st) bubble();
      end else if (ak) begin
        if (!st) begin e_pc = m_pc; e_npc = m_pc + 32'd4; e_instr = rd; e_valid = 1'b1; end
        else begin m_skid.push_back({m_pc, rd}); m_fetch = 1'b0; end
        m_pc = m_pc + 32'd4;
      end else if (!st) bubble();
    end else if (!st) begin
      e = m_skid.pop_front();
      e_pc = e[63:32]; e_npc = e[63:32] + 32'd4; e_instr = e[31:0]; e_valid = 1'b1;
      m_fetch = 1'b1;
    end
  endtask

  // One clock: drive inputs and memory response, check the request side, then IF/ID after the edge.
  task automatic tick(input bit rst, input bit st, input bit fl, input logic [31:0] bt);
    bit          ak;
    logic [31:0] rd;
    @(negedge clk);
    reset = rst; stall = st; flush = fl; branch_target = bt;
    ak = 1'b0;
    if (rst) wcnt = 0;
    else if (m_fetch) begin
      if (wcnt >= lat) begin ak = 1'b1; wcnt = 0; end
      else wcnt++;
    end
    rd = ak ? mem_data(m_pc) : $urandom;
    mif.imem_ack = ak; mif.imem_rdata = rd;
    #1;
    chk("imem_req", {31'b0, mif.imem_req}, {31'b0, m_fetch && !rst});
    if (m_fetch && !rst) chk("imem_addr", mif.imem_addr, m_pc);
    @(posedge clk);
    model_update(rst, st, fl, bt, ak, rd);
    #1;
    chk("pc_out", pc_out, e_pc);
    chk("npc_out", npc_out, e_npc);
    chk("instr_out", instr_out, e_instr);
    chk("valid_out", {31'b0, valid_out}, {31'b0, e_valid});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0;
    mif.imem_ack = 1'b0; mif.imem_rdata = '0;

    // Reset and zero-wait streaming
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    chk("rst_instr", instr_out, NOP);
    lat = 0;
    repeat (3) tick(0, 0, 0, 0);
    chk("zw_instr", instr_out, 32'h33);
    chk("zw_pc", pc_out, 32'h8);
    chk("zw_npc", npc_out, 32'hC);

    // Stall while an ack arrives, then release from the skid buffer
    lat = 1; wcnt = 0;
    repeat (4) tick(0, 1, 0, 0);
    chk("hold_req", {31'b0, mif.imem_req}, 32'h0);
    chk("hold_frozen", instr_out, 32'h33);
    tick(0, 0, 0, 0);
    chk("skid_pc", pc_out, 32'hC);
    chk("skid_instr", instr_out, 32'h44);
    chk("skid_next_addr", mif.imem_addr, 32'h10);
    repeat (2) tick(0, 0, 0, 0);

    // 3-cycle latency
    lat = 3; wcnt = 0;
    repeat (10) tick(0, 0, 0, 0);

    // Flush while a request is outstanding
    tick(1, 0, 0, 0);
    lat = 2; wcnt = 0;
    tick(0, 0, 1, 32'h100);
    repeat (2) tick(0, 0, 0, 0);
    chk("redir_addr", mif.imem_addr, 32'h100);
    chk("redir_valid", {31'b0, valid_out}, 32'h0);

    // Flush and stall together while in HOLD
    lat = 0; wcnt = 0;
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 32'h200);
    chk("hold_flush_addr", mif.imem_addr, 32'h200);
    chk("hold_flush_valid", {31'b0, valid_out}, 32'h0);
    tick(0, 0, 0, 0);

    // PC wrap-around
    tick(0, 0, 1, 32'hFFFF_FFFC);
    tick(0, 0, 0, 0);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_npc", npc_out, 32'h0);
    chk("wrap_next_addr", mif.imem_addr, 32'h0);

    // Reset in the middle of a long wait
    lat = 5; wcnt = 0;
    repeat (2) tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("midrst_addr", mif.imem_addr, 32'h0);
    repeat (7) tick(0, 0, 0, 0);

    // Random traffic
    repeat (400) begin
      if (wcnt == 0) lat = $urandom_range(0, 3);
      tick(($urandom % 50) == 0, ($urandom % 4) == 0, ($urandom % 12) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
